// File: rtl/cxu_pkg.sv
// Shared definitions for CX-attached units: function codes, status codes, FSM states.
package cxu_pkg;
    localparam int CXU_WIDTH    = 32;
    localparam int CXU_N_STATES = 4;

    localparam logic [2:0] CXU_FUNC_MAC   = 3'd0;
    localparam logic [2:0] CXU_FUNC_MUL   = 3'd1;
    localparam logic [2:0] CXU_FUNC_MULHU = 3'd2;
    localparam logic [2:0] CXU_FUNC_READ  = 3'd3;
    localparam logic [2:0] CXU_FUNC_WRITE = 3'd4;

    localparam logic [3:0] CXU_ST_OK      = 4'h0;
    localparam logic [3:0] CXU_ST_ILLEGAL = 4'h1;
    localparam logic [3:0] CXU_ST_WRAP    = 4'h2;

    typedef enum logic [1:0] {
        CXU_IDLE = 2'd0,
        CXU_BUSY = 2'd1,
        CXU_RESP = 2'd2
    } cxu_state_e;

    function automatic logic is_mul_func(input logic [2:0] func);
        return func <= CXU_FUNC_MULHU;
    endfunction
endpackage

// File: rtl/cxu_seq_mul.sv
// Iterative 32x32->64 unsigned shift-add multiplier, one partial product per cycle.
module cxu_seq_mul
    import cxu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [CXU_WIDTH-1:0]   a,
    input  logic [CXU_WIDTH-1:0]   b,
    output logic                   done,
    output logic [2*CXU_WIDTH-1:0] product
);
    logic [CXU_WIDTH-1:0]   a_q;
    logic [CXU_WIDTH-1:0]   b_q;
    logic [2*CXU_WIDTH-1:0] prod_q;
    logic [4:0]             cnt;
    logic                   busy;
    logic [2*CXU_WIDTH-1:0] step_add;

    // product is the accumulated value including this cycle's step, so the
    // final result is usable on the same edge that completes the last step.
    always_comb begin
        step_add = a_q[cnt] ? ({{CXU_WIDTH{1'b0}}, b_q} << cnt) : '0;
        product  = prod_q + step_add;
        done     = busy && (cnt == 5'd31) && !abort;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            a_q    <= a;
            b_q    <= b;
            prod_q <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            prod_q <= product;
            cnt    <= cnt + 5'd1;
            if (cnt == 5'd31) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/cxu_mac.sv
// Stateful multiply-accumulate CXU with four accumulator contexts behind a CX switch slot.
module cxu_mac
    import cxu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cxu_valid,
    input  logic [CXU_WIDTH-1:0] cxu_data0_i,
    input  logic [CXU_WIDTH-1:0] cxu_data1_i,
    input  logic [1:0]           cx_state_id_i,
    input  logic [2:0]           cxu_func_i,
    output logic                 cxu_ready,
    output logic [CXU_WIDTH-1:0] cxu_resp,
    output logic [3:0]           cxu_status,
    output logic [1:0]           fsm_state
);
    // Handshake: cxu_valid is held with stable operands until a one-cycle
    // cxu_ready pulse; dropping cxu_valid while busy aborts the operation.
    cxu_state_e state, state_next;

    logic [CXU_WIDTH-1:0]   acc [CXU_N_STATES];
    logic [2:0]             func_q;
    logic [1:0]             s_q;
    logic                   mul_start, mul_abort, mul_done;
    logic [2*CXU_WIDTH-1:0] mul_product;
    logic                   load;
    logic [CXU_WIDTH-1:0]   resp_d;
    logic [3:0]             status_d;
    logic                   acc_we;
    logic [1:0]             acc_idx;
    logic [CXU_WIDTH-1:0]   acc_wdata;
    logic [CXU_WIDTH:0]     mac_sum;

    cxu_seq_mul u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .abort   (mul_abort),
        .a       (cxu_data0_i),
        .b       (cxu_data1_i),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CXU_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            CXU_IDLE: if (cxu_valid) state_next = is_mul_func(cxu_func_i) ? CXU_BUSY : CXU_RESP;
            CXU_BUSY: if (!cxu_valid) state_next = CXU_IDLE;
                      else if (mul_done) state_next = CXU_RESP;
            CXU_RESP: state_next = CXU_IDLE;
            default:  state_next = CXU_IDLE;
        endcase
    end

    always_comb begin
        mul_start = 1'b0;
        mul_abort = 1'b0;
        load      = 1'b0;
        resp_d    = '0;
        status_d  = CXU_ST_OK;
        acc_we    = 1'b0;
        acc_idx   = s_q;
        acc_wdata = '0;
        mac_sum   = {1'b0, acc[s_q]} + {1'b0, mul_product[CXU_WIDTH-1:0]};
        case (state)
            CXU_IDLE: if (cxu_valid) begin
                acc_idx = cx_state_id_i;
                if (is_mul_func(cxu_func_i)) begin
                    mul_start = 1'b1;
                end else begin
                    load = 1'b1;
                    case (cxu_func_i)
                        CXU_FUNC_READ:  resp_d = acc[cx_state_id_i];
                        CXU_FUNC_WRITE: begin
                            resp_d    = acc[cx_state_id_i];
                            acc_we    = 1'b1;
                            acc_wdata = cxu_data0_i;
                        end
                        default: status_d = CXU_ST_ILLEGAL;
                    endcase
                end
            end
            CXU_BUSY: begin
                mul_abort = !cxu_valid;
                if (mul_done) begin
                    load = 1'b1;
                    case (func_q)
                        CXU_FUNC_MAC: begin
                            resp_d    = mac_sum[CXU_WIDTH-1:0];
                            status_d  = mac_sum[CXU_WIDTH] ? CXU_ST_WRAP : CXU_ST_OK;
                            acc_we    = 1'b1;
                            acc_wdata = mac_sum[CXU_WIDTH-1:0];
                        end
                        CXU_FUNC_MUL: resp_d = mul_product[CXU_WIDTH-1:0];
                        default:      resp_d = mul_product[2*CXU_WIDTH-1:CXU_WIDTH];
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Response registers hold their value only for the RESP cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cxu_ready  <= 1'b0;
            cxu_resp   <= '0;
            cxu_status <= '0;
            func_q     <= '0;
            s_q        <= '0;
            for (int i = 0; i < CXU_N_STATES; i++) acc[i] <= '0;
        end else begin
            cxu_ready  <= load;
            cxu_resp   <= load ? resp_d : '0;
            cxu_status <= load ? status_d : '0;
            if (state == CXU_IDLE && cxu_valid) begin
                func_q <= cxu_func_i;
                s_q    <= cx_state_id_i;
            end
            if (acc_we) acc[acc_idx] <= acc_wdata;
        end
    end

    assign fsm_state = state;
endmodule

// File: tb/tb_cxu_mac.sv
// Directed bench for cxu_mac: latency, results, status, abort and reset behaviour.
module tb_cxu_mac;
    import cxu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cxu_valid = 1'b0;
    logic [31:0] cxu_data0_i = '0;
    logic [31:0] cxu_data1_i = '0;
    logic [1:0]  cx_state_id_i = '0;
    logic [2:0]  cxu_func_i = '0;
    logic        cxu_ready;
    logic [31:0] cxu_resp;
    logic [3:0]  cxu_status;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    cxu_mac dut (
        .clk           (clk),
        .rst           (rst),
        .cxu_valid     (cxu_valid),
        .cxu_data0_i   (cxu_data0_i),
        .cxu_data1_i   (cxu_data1_i),
        .cx_state_id_i (cx_state_id_i),
        .cxu_func_i    (cxu_func_i),
        .cxu_ready     (cxu_ready),
        .cxu_resp      (cxu_resp),
        .cxu_status    (cxu_status),
        .fsm_state     (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full transaction: drive at cycle 0, wait for ready, check latency/resp/status/pulse width.
    task automatic do_op(input string tag, input logic [2:0] func, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_resp, input logic [3:0] exp_status,
                         input int exp_lat);
        int lat;
        @(posedge clk); #1;
        cxu_valid = 1'b1; cxu_func_i = func; cx_state_id_i = s;
        cxu_data0_i = a; cxu_data1_i = b;
        lat = 0;
        @(negedge clk);
        while (!cxu_ready && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_resp"}, {32'b0, cxu_resp}, {32'b0, exp_resp});
        check({tag, "_status"}, {60'b0, cxu_status}, {60'b0, exp_status});
        @(posedge clk); #1;
        cxu_valid = 1'b0;
        @(negedge clk);
        check({tag, "_pulse"}, {63'b0, cxu_ready}, 64'd0);
    endtask

    task automatic start_then_drop(input int drop_cycle, input logic use_reset);
        logic seen;
        @(posedge clk); #1;
        cxu_valid = 1'b1; cxu_func_i = CXU_FUNC_MAC; cx_state_id_i = 2'd0;
        cxu_data0_i = 32'd3; cxu_data1_i = 32'd5;
        repeat (drop_cycle) @(posedge clk);
        #1;
        if (use_reset) begin
            rst = 1'b1;
            #1;
            check("rst_ready", {63'b0, cxu_ready}, 64'd0);
            check("rst_resp", {32'b0, cxu_resp}, 64'd0);
            check("rst_state", {62'b0, fsm_state}, {62'b0, CXU_IDLE});
            @(posedge clk); #1;
            cxu_valid = 1'b0;
            rst = 1'b0;
        end else begin
            cxu_valid = 1'b0;
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (cxu_ready) seen = 1'b1;
        end
        check(use_reset ? "rst_no_ready" : "abort_no_ready", {63'b0, seen}, 64'd0);
        check(use_reset ? "rst_idle" : "abort_idle", {62'b0, fsm_state}, {62'b0, CXU_IDLE});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {63'b0, cxu_ready}, 64'd0);
        check("reset_resp", {32'b0, cxu_resp}, 64'd0);
        check("reset_status", {60'b0, cxu_status}, 64'd0);
        check("reset_state", {62'b0, fsm_state}, {62'b0, CXU_IDLE});
        @(posedge clk); #1;
        rst = 1'b0;

        for (int s = 0; s < 4; s++)
            do_op($sformatf("read_init%0d", s), CXU_FUNC_READ, 2'(s), 32'h0, 32'h0, 32'h0, CXU_ST_OK, 1);

        do_op("mul", CXU_FUNC_MUL, 2'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, CXU_ST_OK, 33);
        do_op("mulhu", CXU_FUNC_MULHU, 2'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, CXU_ST_OK, 33);
        do_op("mul_big", CXU_FUNC_MUL, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, CXU_ST_OK, 33);
        do_op("mulhu_big", CXU_FUNC_MULHU, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, CXU_ST_OK, 33);

        do_op("write2", CXU_FUNC_WRITE, 2'd2, 32'hFFFF_FFF0, 32'h0, 32'h0, CXU_ST_OK, 1);
        do_op("mac2", CXU_FUNC_MAC, 2'd2, 32'd4, 32'd8, 32'h0000_0010, CXU_ST_WRAP, 33);
        do_op("read2", CXU_FUNC_READ, 2'd2, 32'h0, 32'h0, 32'h0000_0010, CXU_ST_OK, 1);
        do_op("read1", CXU_FUNC_READ, 2'd1, 32'h0, 32'h0, 32'h0, CXU_ST_OK, 1);

        do_op("illegal6", 3'd6, 2'd2, 32'h1234_5678, 32'h9, 32'h0, CXU_ST_ILLEGAL, 1);
        do_op("read2_after_ill", CXU_FUNC_READ, 2'd2, 32'h0, 32'h0, 32'h0000_0010, CXU_ST_OK, 1);
        do_op("write_old", CXU_FUNC_WRITE, 2'd1, 32'hDEAD_BEEF, 32'h0, 32'h0, CXU_ST_OK, 1);
        do_op("write_ret", CXU_FUNC_WRITE, 2'd1, 32'h0, 32'h0, 32'hDEAD_BEEF, CXU_ST_OK, 1);

        start_then_drop(10, 1'b0);
        do_op("read0_abort", CXU_FUNC_READ, 2'd0, 32'h0, 32'h0, 32'h0, CXU_ST_OK, 1);
        start_then_drop(20, 1'b1);
        do_op("read0_rst", CXU_FUNC_READ, 2'd0, 32'h0, 32'h0, 32'h0, CXU_ST_OK, 1);
        do_op("read2_rst", CXU_FUNC_READ, 2'd2, 32'h0, 32'h0, 32'h0, CXU_ST_OK, 1);

        do_op("b2b_mac_a", CXU_FUNC_MAC, 2'd3, 32'd2, 32'd7, 32'd14, CXU_ST_OK, 33);
        do_op("b2b_mac_b", CXU_FUNC_MAC, 2'd3, 32'd3, 32'd3, 32'd23, CXU_ST_OK, 33);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
